alt_aeq_adce_sched: RTL and testbench

ALT_AEQ_ADCE_SCHED -- requirements
Module: alt_aeq_adce_sched

---
 rtl/alt_aeq_adce_sched_pkg.sv | 17 +
 rtl/alt_aeq_rr_pick.sv | 36 +++
 rtl/alt_aeq_adce_sched.sv | 173 +++++++++++++++++
 tb/tb_alt_aeq_adce_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_aeq_adce_sched_pkg.sv
// Shared definitions for the AEQ/ADCE calibration scheduler: default
// parameter values and the scheduler state encodings.
package alt_aeq_adce_sched_pkg;

  localparam int          DEF_N_CH         = 5;
  localparam int          DEF_N_SEL        = 3;
  localparam logic [23:0] DEF_RECAL_PERIOD = 24'd1000000;
  localparam int          DEF_ACK_TIMEOUT  = 16;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE      = 2'd0;
  localparam sched_state_t ST_ISSUE     = 2'd1;
  localparam sched_state_t ST_WAIT_BUSY = 2'd2;
  localparam sched_state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/alt_aeq_rr_pick.sv
// Combinational round-robin picker: returns the first pending channel at or
// after the pointer, wrapping from N_CH-1 back to channel 0.
module alt_aeq_rr_pick
  import alt_aeq_adce_sched_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int N_SEL = DEF_N_SEL
) (
  input  logic [N_CH-1:0]  pend,
  input  logic [N_SEL-1:0] ptr,
  output logic [N_SEL-1:0] idx,
  output logic             valid
);

  int               sum;
  logic [N_SEL-1:0] cand;

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N_CH) sum = sum - N_CH;
      cand = N_SEL'(sum);
      if (pend[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alt_aeq_adce_sched.sv
// Calibration scheduler for the adaptive equaliser / DC-offset controller.
// Collects sticky per-channel calibrate and shutdown requests, serves
// calibrations round-robin with a busy/done handshake against the shared
// controller, issues periodic recal sweeps, and fires shutdowns when no
// calibration is outstanding.
module alt_aeq_adce_sched
  import alt_aeq_adce_sched_pkg::*;
#(
  parameter int          N_CH         = DEF_N_CH,
  parameter int          N_SEL        = DEF_N_SEL,
  parameter logic [23:0] RECAL_PERIOD = DEF_RECAL_PERIOD,
  parameter int          ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [N_CH-1:0]  i_cal_req,
  input  logic [N_CH-1:0]  i_shutdown_req,
  input  logic             i_periodic_en,
  input  logic             i_ctl_busy,
  output logic             o_calibrate0q,
  output logic             o_recal0q,
  output logic             o_shutdown_ch0q,
  output logic [N_SEL-1:0] o_current_ch0q,
  output logic [N_CH-1:0]  o_cal_ack0q,
  output logic             o_sched_busy0q,
  output logic             o_timeout_err0q
);

  localparam int               TMR_W    = (RECAL_PERIOD > 24'd1) ? $clog2(RECAL_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RECAL_PERIOD - 24'd1);
  localparam int               ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [N_SEL-1:0] CH_LAST  = N_SEL'(N_CH - 1);

  sched_state_t     state, state_nxt;
  logic [N_CH-1:0]  cal_pend, recal_flag, shut_pend;
  logic [N_SEL-1:0] ptr, ptr_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [ACK_W-1:0] ack_cnt, ack_cnt_nxt;

  logic [N_SEL-1:0] pick_idx, shut_idx, cur_nxt;
  logic             pick_valid, shut_valid, tmr_expire;
  logic [N_CH-1:0]  cur_mask, cal_clr, recal_clr, shut_clr, ack_nxt;
  logic             cal_pulse_nxt, recal_pulse_nxt, shut_pulse_nxt, err_nxt;

  alt_aeq_rr_pick #(
    .N_CH  (N_CH),
    .N_SEL (N_SEL)
  ) u_rr_pick (
    .pend  (cal_pend),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Lowest-index pending shutdown.
  always_comb begin
    shut_idx   = '0;
    shut_valid = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (shut_pend[i]) begin
        shut_idx   = N_SEL'(i);
        shut_valid = 1'b1;
      end
    end
  end

  // Periodic recal timer: advances only while idle, cleared when disabled.
  always_comb begin
    tmr_expire = i_periodic_en && (state == ST_IDLE) && (tmr == TMR_LAST);
    if (!i_periodic_en)      tmr_nxt = '0;
    else if (state != ST_IDLE) tmr_nxt = tmr;
    else if (tmr_expire)     tmr_nxt = '0;
    else                     tmr_nxt = tmr + 1'b1;
  end

  // Scheduler next-state, pulse and pending-clear decisions.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    cur_nxt         = o_current_ch0q;
    ack_cnt_nxt     = ack_cnt;
    cal_clr         = '0;
    recal_clr       = '0;
    shut_clr        = '0;
    ack_nxt         = '0;
    cal_pulse_nxt   = 1'b0;
    recal_pulse_nxt = 1'b0;
    shut_pulse_nxt  = 1'b0;
    err_nxt         = o_timeout_err0q;
    cur_mask        = N_CH'(1) << o_current_ch0q;

    case (state)
      ST_IDLE: begin
        if (!i_ctl_busy) begin
          if (pick_valid) begin
            state_nxt = ST_ISSUE;
            cur_nxt   = pick_idx;
          end else if (shut_valid) begin
            shut_pulse_nxt = 1'b1;
            cur_nxt        = shut_idx;
            shut_clr       = N_CH'(1) << shut_idx;
          end
        end
      end
      ST_ISSUE: begin
        state_nxt   = ST_WAIT_BUSY;
        ack_cnt_nxt = '0;
        if (|(recal_flag & cur_mask)) recal_pulse_nxt = 1'b1;
        else                          cal_pulse_nxt   = 1'b1;
      end
      ST_WAIT_BUSY: begin
        if (i_ctl_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          // Controller never picked the request up: drop it and flag it.
          err_nxt   = 1'b1;
          cal_clr   = cur_mask;
          state_nxt = ST_IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_ctl_busy) begin
          ack_nxt   = cur_mask;
          cal_clr   = cur_mask;
          recal_clr = cur_mask;
          ptr_nxt   = (o_current_ch0q == CH_LAST) ? '0 : o_current_ch0q + 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, pending sets and registered outputs; new requests win over clears.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= ST_IDLE;
      cal_pend        <= '0;
      recal_flag      <= '0;
      shut_pend       <= '0;
      ptr             <= '0;
      tmr             <= '0;
      ack_cnt         <= '0;
      o_calibrate0q   <= 1'b0;
      o_recal0q       <= 1'b0;
      o_shutdown_ch0q <= 1'b0;
      o_current_ch0q  <= '0;
      o_cal_ack0q     <= '0;
      o_sched_busy0q  <= 1'b0;
      o_timeout_err0q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state           <= state_nxt;
      cal_pend        <= (cal_pend & ~cal_clr) | i_cal_req | {N_CH{tmr_expire}};
      recal_flag      <= (recal_flag & ~recal_clr) | {N_CH{tmr_expire}};
      shut_pend       <= (shut_pend & ~shut_clr) | i_shutdown_req;
      ptr             <= ptr_nxt;
      tmr             <= tmr_nxt;
      ack_cnt         <= ack_cnt_nxt;
      o_calibrate0q   <= cal_pulse_nxt;
      o_recal0q       <= recal_pulse_nxt;
      o_shutdown_ch0q <= shut_pulse_nxt;
      o_current_ch0q  <= cur_nxt;
      o_cal_ack0q     <= ack_nxt;
      o_sched_busy0q  <= (state_nxt != ST_IDLE);
      o_timeout_err0q <= err_nxt;
    end
  end

endmodule

// File: tb/tb_alt_aeq_adce_sched.sv
// Bench for alt_aeq_adce_sched: directed scenarios with hand-computed
// expectations plus a randomized run checked every cycle against a
// transaction-level model of the scheduler.
module tb_alt_aeq_adce_sched;

  localparam int NC = 5;
  localparam int RP = 100;
  localparam int AT = 16;

  localparam int PH_ANNOUNCE = 0;
  localparam int PH_AWAIT    = 1;
  localparam int PH_WORK     = 2;

  logic          i_clock;
  logic          i_reset;
  logic [NC-1:0] i_cal_req;
  logic [NC-1:0] i_shutdown_req;
  logic          i_periodic_en;
  logic          i_ctl_busy;
  logic          o_calibrate0q;
  logic          o_recal0q;
  logic          o_shutdown_ch0q;
  logic [2:0]    o_current_ch0q;
  logic [NC-1:0] o_cal_ack0q;
  logic          o_sched_busy0q;
  logic          o_timeout_err0q;

  alt_aeq_adce_sched #(
    .N_CH         (NC),
    .N_SEL        (3),
    .RECAL_PERIOD (24'd100),
    .ACK_TIMEOUT  (AT)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_cal_req       (i_cal_req),
    .i_shutdown_req  (i_shutdown_req),
    .i_periodic_en   (i_periodic_en),
    .i_ctl_busy      (i_ctl_busy),
    .o_calibrate0q   (o_calibrate0q),
    .o_recal0q       (o_recal0q),
    .o_shutdown_ch0q (o_shutdown_ch0q),
    .o_current_ch0q  (o_current_ch0q),
    .o_cal_ack0q     (o_cal_ack0q),
    .o_sched_busy0q  (o_sched_busy0q),
    .o_timeout_err0q (o_timeout_err0q)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_on   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  bit m_calp[NC];
  bit m_rcf[NC];
  bit m_shp[NC];
  int m_ptr, m_tmr, m_ch, m_phase, m_wait;
  bit m_active;
  bit m_o_cal, m_o_recal, m_o_shut, m_o_err;
  int m_o_cur, m_o_ack;

  task automatic model_step();
    bit expire;
    bit clr_cal[NC];
    bit clr_rcf[NC];
    bit clr_shp[NC];
    int pick;
    int low;
    if (i_reset) begin
      for (int c = 0; c < NC; c++) begin m_calp[c] = 0; m_rcf[c] = 0; m_shp[c] = 0; end
      m_ptr = 0; m_tmr = 0; m_ch = 0; m_phase = PH_ANNOUNCE; m_wait = 0; m_active = 0;
      m_o_cal = 0; m_o_recal = 0; m_o_shut = 0; m_o_err = 0; m_o_cur = 0; m_o_ack = 0;
      return;
    end
    m_o_cal = 0; m_o_recal = 0; m_o_shut = 0; m_o_ack = 0;
    expire = 0; pick = -1; low = -1;
    for (int c = 0; c < NC; c++) begin clr_cal[c] = 0; clr_rcf[c] = 0; clr_shp[c] = 0; end

    if (!i_periodic_en) m_tmr = 0;
    else if (!m_active) begin
      if (m_tmr == RP - 1) begin m_tmr = 0; expire = 1; end
      else m_tmr++;
    end

    if (!m_active) begin
      if (!i_ctl_busy) begin
        for (int k = NC - 1; k >= 0; k--) if (m_calp[(m_ptr + k) % NC]) pick = (m_ptr + k) % NC;
        for (int c = NC - 1; c >= 0; c--) if (m_shp[c]) low = c;
        if (pick >= 0) begin
          m_active = 1; m_phase = PH_ANNOUNCE; m_ch = pick; m_o_cur = pick;
        end else if (low >= 0) begin
          m_o_shut = 1; m_o_cur = low; clr_shp[low] = 1;
        end
      end
    end else if (m_phase == PH_ANNOUNCE) begin
      if (m_rcf[m_ch]) m_o_recal = 1; else m_o_cal = 1;
      m_phase = PH_AWAIT; m_wait = 0;
    end else if (m_phase == PH_AWAIT) begin
      if (i_ctl_busy) m_phase = PH_WORK;
      else begin
        m_wait++;
        if (m_wait == AT) begin m_o_err = 1; clr_cal[m_ch] = 1; m_active = 0; end
      end
    end else begin
      if (!i_ctl_busy) begin
        m_o_ack = 1 << m_ch; clr_cal[m_ch] = 1; clr_rcf[m_ch] = 1;
        m_ptr = (m_ch + 1) % NC; m_active = 0;
      end
    end

    for (int c = 0; c < NC; c++) begin
      m_calp[c] = (m_calp[c] && !clr_cal[c]) || i_cal_req[c] || expire;
      m_rcf[c]  = (m_rcf[c] && !clr_rcf[c]) || expire;
      m_shp[c]  = (m_shp[c] && !clr_shp[c]) || i_shutdown_req[c];
    end
  endtask

  always @(posedge i_clock) begin
    cyc++;
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clock) begin
    if (chk_on) begin
      check("calibrate", 32'(o_calibrate0q), 32'(m_o_cal));
      check("recal", 32'(o_recal0q), 32'(m_o_recal));
      check("shutdown", 32'(o_shutdown_ch0q), 32'(m_o_shut));
      check("current_ch", 32'(o_current_ch0q), m_o_cur);
      check("cal_ack", 32'(o_cal_ack0q), m_o_ack);
      check("sched_busy", 32'(o_sched_busy0q), 32'(m_active));
      check("timeout_err", 32'(o_timeout_err0q), 32'(m_o_err));
    end
  end

  // ---------------- event logs ----------------
  typedef struct { int cyc; int val; } ev_t;
  ev_t cal_log[$];
  ev_t recal_log[$];
  ev_t shut_log[$];
  ev_t ack_log[$];
  int  err_cyc = -1;

  always @(negedge i_clock) begin
    if (o_calibrate0q === 1'b1)   cal_log.push_back(ev_t'{cyc, int'(o_current_ch0q)});
    if (o_recal0q === 1'b1)       recal_log.push_back(ev_t'{cyc, int'(o_current_ch0q)});
    if (o_shutdown_ch0q === 1'b1) shut_log.push_back(ev_t'{cyc, int'(o_current_ch0q)});
    if (!$isunknown(o_cal_ack0q) && o_cal_ack0q != '0) ack_log.push_back(ev_t'{cyc, int'(o_cal_ack0q)});
    if (o_timeout_err0q === 1'b1 && err_cyc < 0) err_cyc = cyc;
  end

  task automatic clear_logs();
    cal_log.delete(); recal_log.delete(); shut_log.delete(); ack_log.delete();
    err_cyc = -1;
  endtask

  // ---------------- stimulus ----------------
  bit resp_en    = 0;
  int resp_delay = 3;
  int resp_len   = 4;
  int resp_cd    = 0;
  int resp_hi    = 0;
  bit extra_busy = 0;

  // One cycle: apply requests at the falling edge; the controller stand-in
  // raises busy resp_delay cycles after a pulse and holds it resp_len cycles.
  task automatic tick(input logic [NC-1:0] cal, input logic [NC-1:0] sh);
    @(negedge i_clock);
    i_cal_req      = cal;
    i_shutdown_req = sh;
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) resp_hi = resp_len;
    end
    if (resp_en && (o_calibrate0q === 1'b1 || o_recal0q === 1'b1)) resp_cd = resp_delay;
    i_ctl_busy = (resp_hi > 0) || extra_busy;
    if (resp_hi > 0) resp_hi--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, '0);
  endtask

  task automatic do_reset();
    resp_cd = 0; resp_hi = 0;
    i_reset = 1'b1;
    tick('0, '0);
    i_reset = 1'b0;
  endtask

  int order[6] = '{0, 1, 2, 3, 4, 0};
  int c0;
  bit injected;

  initial begin
    i_reset = 1'b1; i_cal_req = '0; i_shutdown_req = '0;
    i_periodic_en = 1'b0; i_ctl_busy = 1'b0;

    // Reset state.
    do_reset();
    chk_on = 1;
    check("rst_calibrate", 32'(o_calibrate0q), 0);
    check("rst_current", 32'(o_current_ch0q), 0);
    check("rst_busy", 32'(o_sched_busy0q), 0);
    check("rst_err", 32'(o_timeout_err0q), 0);

    // Single request on channel 2 with a well-behaved controller.
    clear_logs();
    resp_en = 1; resp_delay = 3; resp_len = 10;
    tick(5'b00100, '0);
    c0 = cyc;
    idle(30);
    check("single_cal_count", cal_log.size(), 1);
    if (cal_log.size() > 0) begin
      check("single_latency", cal_log[0].cyc - c0, 3);
      check("single_ch", cal_log[0].val, 2);
    end
    check("single_ack_count", ack_log.size(), 1);
    if (ack_log.size() > 0) check("single_ack_val", ack_log[0].val, 5'b00100);
    check("single_recal_count", recal_log.size(), 0);

    // All channels at once, then channel 0 again after channel 1 is served.
    do_reset(); clear_logs();
    resp_delay = 2; resp_len = 3;
    tick(5'b11111, '0);
    injected = 0;
    for (int n = 0; n < 150; n++) begin
      if (!injected && ack_log.size() >= 2) begin
        injected = 1;
        tick(5'b00001, '0);
      end else tick('0, '0);
    end
    check("rr_ack_count", ack_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < ack_log.size()) check($sformatf("rr_order_%0d", i), ack_log[i].val, 1 << order[i]);

    // Controller never goes busy: timeout 16 cycles after the pulse.
    do_reset(); clear_logs();
    resp_en = 0;
    tick(5'b00010, '0);
    idle(40);
    check("to_cal_count", cal_log.size(), 1);
    if (cal_log.size() > 0) check("to_delay", err_cyc - cal_log[0].cyc, 16);
    check("to_ack_count", ack_log.size(), 0);
    check("to_idle", 32'(o_sched_busy0q), 0);
    check("to_err", 32'(o_timeout_err0q), 1);
    do_reset();
    check("to_err_cleared", 32'(o_timeout_err0q), 0);

    // Calibrate and shutdown pending on channel 3 together.
    clear_logs();
    resp_en = 1; resp_delay = 2; resp_len = 3;
    tick(5'b01000, 5'b01000);
    idle(60);
    check("cs_ack_count", ack_log.size(), 1);
    check("cs_shut_count", shut_log.size(), 1);
    if (ack_log.size() > 0 && shut_log.size() > 0) begin
      check("cs_ack_val", ack_log[0].val, 5'b01000);
      check("cs_shut_ch", shut_log[0].val, 3);
      check("cs_shut_after_ack", 32'(shut_log[0].cyc > ack_log[0].cyc), 1);
    end

    // Reset while the controller is busy.
    do_reset(); clear_logs();
    resp_delay = 2; resp_len = 20;
    tick(5'b00100, '0);
    idle(8);
    check("mid_busy", 32'(o_sched_busy0q), 1);
    clear_logs();
    do_reset();
    check("mid_rst_cal", 32'(o_calibrate0q), 0);
    check("mid_rst_recal", 32'(o_recal0q), 0);
    check("mid_rst_shut", 32'(o_shutdown_ch0q), 0);
    check("mid_rst_cur", 32'(o_current_ch0q), 0);
    check("mid_rst_ack", 32'(o_cal_ack0q), 0);
    check("mid_rst_busy", 32'(o_sched_busy0q), 0);
    idle(40);
    check("mid_no_ack", ack_log.size(), 0);
    check("mid_no_cal", cal_log.size(), 0);

    // Periodic sweep with RECAL_PERIOD = 100.
    do_reset(); clear_logs();
    resp_delay = 2; resp_len = 2;
    i_periodic_en = 1'b1;
    c0 = cyc;
    idle(160);
    i_periodic_en = 1'b0;
    idle(5);
    check("sweep_count", recal_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < recal_log.size()) check($sformatf("sweep_ch_%0d", i), recal_log[i].val, i);
    if (recal_log.size() > 0) check("sweep_start", recal_log[0].cyc - c0, 102);
    check("sweep_no_cal", cal_log.size(), 0);
    check("sweep_acks", ack_log.size(), 5);

    // Randomized traffic checked by the model every cycle.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [NC-1:0] cal;
      logic [NC-1:0] sh;
      cal = ($urandom_range(0, 9) == 0) ? NC'($urandom) : '0;
      sh  = ($urandom_range(0, 14) == 0) ? NC'($urandom) : '0;
      extra_busy = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) i_periodic_en = ~i_periodic_en;
      i_reset    = ($urandom_range(0, 499) == 0);
      resp_delay = $urandom_range(1, 20);
      resp_len   = $urandom_range(1, 6);
      tick(cal, sh);
    end
    i_reset = 1'b0; i_periodic_en = 1'b0; extra_busy = 0;
    idle(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
